sram_responder: RTL and testbench



---
 rtl/sram_responder_if.sv | 24 ++
 rtl/sram_responder.sv | 143 ++++++++++++++
 tb/tb_sram_responder.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/sram_responder_if.sv
// Request/response bundle between a core port and its SRAM responder.
interface sram_responder_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  sram_rd_en;
    logic [ADDR_WIDTH-1:0] sram_rd_addr;
    logic [DATA_WIDTH-1:0] sram_rd_data;
    logic                  sram_rd_valid;
    logic                  sram_wr_en;
    logic [ADDR_WIDTH-1:0] sram_wr_addr;
    logic [DATA_WIDTH-1:0] sram_wr_data;
    logic [3:0]            sram_wr_mask;

    modport master (
        output sram_rd_en, sram_rd_addr, sram_wr_en, sram_wr_addr, sram_wr_data, sram_wr_mask,
        input  sram_rd_data, sram_rd_valid
    );

    modport slave (
        input  sram_rd_en, sram_rd_addr, sram_wr_en, sram_wr_addr, sram_wr_data, sram_wr_mask,
        output sram_rd_data, sram_rd_valid
    );
endinterface

// File: rtl/sram_responder.sv
// Word-addressed SRAM responder: programmable-latency reads, single-cycle byte-masked writes.
// Optional SRAM_RESP_RANDOM_STALL_EN adds 0-3 LFSR-driven extra wait cycles per read.
module sram_responder #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH_LOG2 = 14,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic              clock,
    input  logic              reset,
    sram_responder_if.slave   bus
);
    localparam int unsigned DEPTH     = 1 << DEPTH_LOG2;
    localparam int unsigned NUM_LANES = 4;
    localparam int unsigned CNT_W     = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        VALID = 2'd2
    } state_e;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DEPTH_LOG2-1:0] idx_q, idx_d;
    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;

    logic [DEPTH_LOG2-1:0] rd_idx_c, wr_idx_c;
    logic [DATA_WIDTH-1:0] rd_word_c;
    logic [CNT_W-1:0]      load_c;
    logic                  start_c;
    logic                  unused_c;

    assign rd_idx_c = bus.sram_rd_addr[DEPTH_LOG2+1:2];
    assign wr_idx_c = bus.sram_wr_addr[DEPTH_LOG2+1:2];
    assign unused_c = ^{bus.sram_rd_addr[ADDR_WIDTH-1:DEPTH_LOG2+2], bus.sram_rd_addr[1:0],
                        bus.sram_wr_addr[ADDR_WIDTH-1:DEPTH_LOG2+2], bus.sram_wr_addr[1:0]};

`ifdef SRAM_RESP_RANDOM_STALL_EN
    logic [15:0] lfsr_q, lfsr_d;

    assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    assign load_c = CNT_W'(RD_LATENCY - 1) + CNT_W'(lfsr_q[1:0]);

    always_ff @(posedge clock) begin
        if (reset) lfsr_q <= 16'hACE1;
        else       lfsr_q <= lfsr_d;
    end
`else
    assign load_c = CNT_W'(RD_LATENCY - 1);
`endif

    // Read word as it will look after this edge's write, so captures see merged data.
    always_comb begin
        rd_word_c = mem[rd_idx_c];
        for (int i = 0; i < NUM_LANES; i++) begin
            if (bus.sram_wr_en && bus.sram_wr_mask[i] && (wr_idx_c == rd_idx_c))
                rd_word_c[8*i +: 8] = bus.sram_wr_data[8*i +: 8];
        end
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_LANES; i++) begin
            if (bus.sram_wr_en && bus.sram_wr_mask[i])
                mem[wr_idx_c][8*i +: 8] <= bus.sram_wr_data[8*i +: 8];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        valid_d = 1'b0;
        data_d  = data_q;
        start_c = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.sram_rd_en) start_c = 1'b1;
            end
            WAIT: begin
                if (!bus.sram_rd_en) begin
                    state_d = IDLE;
                end else if (rd_idx_c != idx_q) begin
                    start_c = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = VALID;
                        valid_d = 1'b1;
                        data_d  = rd_word_c;
                    end
                end
            end
            VALID: begin
                if (!bus.sram_rd_en) begin
                    state_d = IDLE;
                end else if (rd_idx_c != idx_q) begin
                    start_c = 1'b1;
                end else begin
                    valid_d = 1'b1;
                    data_d  = rd_word_c;
                end
            end
            default: state_d = IDLE;
        endcase

        // A new request (from IDLE or an address change) latches the index and reloads the counter.
        if (start_c) begin
            idx_d = rd_idx_c;
            cnt_d = load_c;
            if (load_c == CNT_W'(0)) begin
                state_d = VALID;
                valid_d = 1'b1;
                data_d  = rd_word_c;
            end else begin
                state_d = WAIT;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign bus.sram_rd_valid = valid_q;
    assign bus.sram_rd_data  = data_q;
endmodule

// File: tb/tb_sram_responder.sv
// Bench for sram_responder: four instances (RD_LATENCY 1..4) share one stimulus stream
// and are checked against a run-length/latency memory model.
module tb_sram_responder;
    logic        clock = 1'b0;
    logic        reset;
    logic        rd_en;
    logic [31:0] rd_addr;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_mask;

    logic        obs_valid [4];
    logic [31:0] obs_data  [4];

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        sram_responder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) ifc ();
        sram_responder #(
            .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH_LOG2(14), .RD_LATENCY(g + 1)
        ) dut (
            .clock (clock),
            .reset (reset),
            .bus   (ifc.slave)
        );
        assign ifc.sram_rd_en   = rd_en;
        assign ifc.sram_rd_addr = rd_addr;
        assign ifc.sram_wr_en   = wr_en;
        assign ifc.sram_wr_addr = wr_addr;
        assign ifc.sram_wr_data = wr_data;
        assign ifc.sram_wr_mask = wr_mask;
        assign obs_valid[g] = ifc.sram_rd_valid;
        assign obs_data[g]  = ifc.sram_rd_data;
    end

    // Reference model: memory contents plus length of the current unbroken request run.
    logic [31:0] mdl [int unsigned];
    int          run = 0;
    logic        prev_ok = 1'b0;
    logic [13:0] prev_idx = '0;
    int          cyc = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic tick();
        logic [13:0] ri, wi;
        logic [31:0] w;
        logic        have;
        logic        ev;
        @(posedge clock);
        cyc++;
        ri = rd_addr[15:2];
        wi = wr_addr[15:2];
        if (wr_en) begin
            w = mdl.exists(32'(wi)) ? mdl[32'(wi)] : 32'h0;
            for (int i = 0; i < 4; i++)
                if (wr_mask[i]) w[8*i +: 8] = wr_data[8*i +: 8];
            mdl[32'(wi)] = w;
        end
        if (reset || !rd_en)                  run = 0;
        else if (prev_ok && ri == prev_idx)   run = (run < 100) ? run + 1 : run;
        else                                  run = 1;
        prev_ok  = !reset && rd_en;
        prev_idx = ri;
        have = mdl.exists(32'(ri));
        w    = have ? mdl[32'(ri)] : 32'h0;
        #1;
        for (int g = 0; g < 4; g++) begin
            ev = !reset && (run >= g + 1);
            check($sformatf("valid_l%0d", g + 1), 32'(obs_valid[g]), 32'(ev));
            if (ev && have) check($sformatf("data_l%0d", g + 1), obs_data[g], w);
            if (reset)      check($sformatf("rst_data_l%0d", g + 1), obs_data[g], 32'h0);
        end
    endtask

    initial begin
        logic [3:0] ridx;
        logic [3:0] widx;
        reset = 1'b1; rd_en = 1'b1; rd_addr = 32'h0;
        wr_en = 1'b0; wr_addr = 32'h0; wr_data = 32'h0; wr_mask = 4'h0;
        #2;

        // Reset held with a pending request; preload array while still in reset.
        repeat (3) tick();
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1; wr_addr = 32'(i * 4); wr_mask = 4'hF;
            wr_data = (i == 8) ? 32'h0 : $urandom();
            tick();
        end
        wr_addr = 32'h40;  wr_data = 32'hDEADBEEF; tick();
        wr_addr = 32'h100; wr_data = 32'hFFFFFFFF; tick();
        wr_en = 1'b0;

        // Release: L=2 instance valid exactly two cycles later.
        reset = 1'b0; rd_addr = 32'h0;
        tick(); check("rel_l2_early", 32'(obs_valid[1]), 32'd0);
        tick(); check("rel_l2_rise", 32'(obs_valid[1]), 32'd1);

        // Hold 0x40 with L=1.
        rd_addr = 32'h40;
        tick(); check("hold40_valid", 32'(obs_valid[0]), 32'd1);
        check("hold40_data", obs_data[0], 32'hDEADBEEF);
        for (int i = 0; i < 5; i++) begin
            tick(); check("hold40_stay", 32'(obs_valid[0]), 32'd1);
        end

        // Masked write then read.
        rd_en = 1'b0; wr_en = 1'b1; wr_addr = 32'h100; wr_data = 32'h11223344; wr_mask = 4'b0101;
        tick();
        wr_en = 1'b0; rd_en = 1'b1; rd_addr = 32'h100;
        tick(); check("mask_data", obs_data[0], 32'hFF22FF44);

        // Address switch during wait, L=3.
        rd_en = 1'b0; tick();
        rd_en = 1'b1; rd_addr = 32'h0; tick();
        rd_addr = 32'h4;
        tick(); check("sw_l3_c1", 32'(obs_valid[2]), 32'd0);
        tick(); check("sw_l3_c2", 32'(obs_valid[2]), 32'd0);
        tick(); check("sw_l3_c3", 32'(obs_valid[2]), 32'd1);
        check("sw_l3_data", obs_data[2], mdl[32'd1]);

        // Write on the L=2 capture edge.
        rd_en = 1'b0; tick();
        rd_en = 1'b1; rd_addr = 32'h20; tick();
        wr_en = 1'b1; wr_addr = 32'h20; wr_data = 32'hCAFEF00D; wr_mask = 4'hF;
        tick(); wr_en = 1'b0;
        check("coll_valid", 32'(obs_valid[1]), 32'd1);
        check("coll_data", obs_data[1], 32'hCAFEF00D);

        // Reset while L=4 waits; request restarts from scratch.
        rd_en = 1'b0; tick();
        rd_en = 1'b1; rd_addr = 32'h4; tick(); tick();
        reset = 1'b1; tick(); check("rstw_valid", 32'(obs_valid[3]), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(); check("rstw_wait", 32'(obs_valid[3]), 32'd0);
        end
        tick(); check("rstw_rise", 32'(obs_valid[3]), 32'd1);

        // Random traffic with wrapped upper address bits.
        ridx = 4'd0;
        for (int n = 0; n < 600; n++) begin
            reset = ($urandom_range(0, 59) == 0);
            rd_en = ($urandom_range(0, 99) < 88);
            if ($urandom_range(0, 3) == 0) ridx = 4'($urandom_range(0, 15));
            rd_addr = {16'($urandom()), 10'd0, ridx, 2'($urandom())};
            wr_en = ($urandom_range(0, 99) < 40);
            widx  = ($urandom_range(0, 2) == 0) ? ridx : 4'($urandom_range(0, 15));
            wr_addr = {16'($urandom()), 10'd0, widx, 2'($urandom())};
            wr_data = $urandom();
            wr_mask = 4'($urandom());
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
